varlat_bank_arb_resp_demux: RTL

//   Bank-side end of the variable-latency TCDM crossbar. Round-robin arbitrates NumIn master

---
 rtl/varlat_bank_arb_resp_demux_if.sv | 43 ++++
 rtl/varlat_bank_arb_resp_demux.sv | 133 +++++++++++++
 2 files changed

// File: rtl/varlat_bank_arb_resp_demux_if.sv
// rtl/varlat_bank_arb_resp_demux_if.sv - master-side and bank-side bus bundle for one bank arbiter
//
// Purpose: groups the per-master request/grant/response lines and the single
//          bank port so the arbiter takes one bus port.
// Signals:
//   req        [NumIn]                    request per master
//   data       [NumIn][ReqDataWidth]      request payload per master
//   gnt        [NumIn]                    grant per master (onehot0)
//   vld        [NumIn]                    response valid per master (onehot0)
//   rdata      [NumIn][RespDataWidth]     response payload per master
//   bank_req                              request to bank
//   bank_data  [ReqDataWidth]             payload to bank
//   bank_gnt                              bank accepts request
//   bank_vld                              bank response valid (in request order)
//   bank_rdata [RespDataWidth]            bank response payload
// Modports: slave = arbiter view, master = masters + bank model view.

interface varlat_bank_arb_resp_demux_if #(
    parameter int unsigned NumIn         = 4,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32
);
    logic [NumIn-1:0]                    req;
    logic [NumIn-1:0][ReqDataWidth-1:0]  data;
    logic [NumIn-1:0]                    gnt;
    logic [NumIn-1:0]                    vld;
    logic [NumIn-1:0][RespDataWidth-1:0] rdata;
    logic                                bank_req;
    logic [ReqDataWidth-1:0]             bank_data;
    logic                                bank_gnt;
    logic                                bank_vld;
    logic [RespDataWidth-1:0]            bank_rdata;

    modport slave (
        input  req, data, bank_gnt, bank_vld, bank_rdata,
        output gnt, vld, rdata, bank_req, bank_data
    );

    modport master (
        output req, data, bank_gnt, bank_vld, bank_rdata,
        input  gnt, vld, rdata, bank_req, bank_data
    );
endinterface

// File: rtl/varlat_bank_arb_resp_demux.sv
// rtl/varlat_bank_arb_resp_demux.sv - round-robin bank arbiter with in-order response demux
//
// Purpose: arbitrates NumIn master requests onto one bank port (round-robin,
//          same-cycle grant), remembers each granted master in an in-order ID
//          FIFO and steers bank responses back to the issuing master.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous reset, active-low
//   bus     slave view of the master/bank bus bundle
//   idle_o  1 when no transaction is outstanding

module varlat_bank_arb_resp_demux #(
    parameter int unsigned NumIn          = 4,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    varlat_bank_arb_resp_demux_if.slave   bus,
    output logic                          idle_o
);
    localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    if (NumIn < 1) begin : g_bad_numin
        $fatal(1, "NumIn must be at least 1");
    end
    if (MaxOutstanding < 1) begin : g_bad_maxout
        $fatal(1, "MaxOutstanding must be at least 1");
    end

    logic [IdxW-1:0] rr_q, rr_d;
    logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];

    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] head;
    logic            full;
    logic            hs;
    logic            pop;

    // Scan starting at rr_q; with no request the winner stays rr_q so data
    // still has a defined source.
    always_comb begin
        logic found;
        winner = rr_q;
        found  = 1'b0;
        for (int i = 0; i < int'(NumIn); i++) begin
            if (!found && bus.req[(int'(rr_q) + i) % int'(NumIn)]) begin
                winner = IdxW'((int'(rr_q) + i) % int'(NumIn));
                found  = 1'b1;
            end
        end
    end

    // A full FIFO blocks issue even when a response pops this same cycle.
    assign full         = (cnt_q == CntW'(MaxOutstanding));
    assign bus.bank_req = (|bus.req) & ~full;
    assign hs           = bus.bank_req & bus.bank_gnt;
    assign bus.bank_data = bus.data[winner];

    assign head   = fifo_q[rd_q];
    assign pop    = bus.bank_vld & (cnt_q != '0);
    assign idle_o = (cnt_q == '0);

    always_comb begin
        bus.gnt   = '0;
        bus.vld   = '0;
        bus.rdata = '0;
        for (int k = 0; k < int'(NumIn); k++) begin
            bus.gnt[k]   = hs  && (winner == IdxW'(k));
            bus.vld[k]   = pop && (head == IdxW'(k));
            bus.rdata[k] = bus.bank_rdata;
        end
    end

    // Pointer wrap is explicit so non-power-of-2 depths work.
    always_comb begin
        rr_d  = rr_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (hs) begin
            rr_d = (winner == IdxW'(NumIn - 1)) ? '0 : winner + 1'b1;
            wr_d = (wr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (rd_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_q + 1'b1;
        end
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            rr_q  <= rr_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entries are only read while cnt_q says they are valid, so no reset.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_q[wr_q] <= winner;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(bus.gnt)) else $error("gnt_o not onehot0");
            assert ($onehot0(bus.vld)) else $error("vld_o not onehot0");
            assert (cnt_q <= CntW'(MaxOutstanding)) else $error("ID FIFO count overflow");
            // Protocol error by the bank, not by this block: reported, not fatal.
            assert (!(bus.bank_vld && cnt_q == '0))
                else $warning("protocol error: bank vld_i with no outstanding transaction");
        end
    end
`endif
endmodule
